apb_slave_bridge: RTL and testbench
===================================

# apb_slave_bridge

Parametrised APB4 completer that turns APB transfers into request/acknowledge transactions toward a register back end, such as the UART register file. It captures the setup phase, issues a one-cycle read or write request, and holds `pready` low until the back end acknowledges. It supports byte strobes, rejects misaligned accesses locally, and can optionally time out a back end that never acknowledges.

## Interface
Parameters:
- `ADDR_W`, default 12: byte address width.
- `DATA_W`, default 32: data width; must be a multiple of 8, from 8 to 64.
- `TIMEOUT`, default 16: maximum cycles spent waiting for an acknowledge (used only with `APB_BRIDGE_TIMEOUT_EN`); must be 2 or more.

Ports:
- `pclk` in 1: clock.
- `prst_n` in 1: reset, asynchronous, active-low.
- `paddr` in ADDR_W: APB address.
- `psel`, `penable`, `pwrite` in 1: APB control.
- `pwdata` in DATA_W: APB write data.
- `pstrb` in DATA_W/8: APB byte strobes.
- `pready` out 1: transfer complete.
- `prdata` out DATA_W: read data.
- `pslverr` out 1: transfer error.
- `wr_en`, `rd_en` out 1: one-cycle back-end request pulses.
- `waddr`, `raddr` out ADDR_W: request addresses.
- `wdata` out DATA_W: write data with unstrobed bytes zeroed.
- `wstrb` out DATA_W/8: write byte strobes.
- `wack`, `rack` in 1: back-end acknowledges.
- `waddrerr`, `raddrerr` in 1: back-end error flags, qualified by the matching acknowledge.
- `rdata` in DATA_W: back-end read data, qualified by `rack`.

## Operation
- The controller is a four-state FSM:
  - **IDLE**: on `psel & ~penable`, capture `paddr`, `pwrite`, `pwdata`, `pstrb`.
    - If `paddr[log2(DATA_W/8)-1:0] != 0`, go to RESP with error set.
    - If a write has `pstrb == 0`, go to RESP with no error and no request.
    - Otherwise go to REQ.
  - **REQ** (one cycle): drive `wr_en` or `rd_en` high for that cycle only. Sample acknowledges; on the matching ack go to RESP, else go to WAIT.
  - **WAIT**: on the matching ack go to RESP.
  - **RESP** (one cycle): `pready = 1`, drive the registered `prdata`/`pslverr`, then return to IDLE.
- Matching ack means `wack` for a write and `rack` for a read.
  - A non-matching ack is ignored.
  - Any ack in IDLE or RESP is ignored.
- On an ack, register the response: `prdata <= rdata` for reads (0 for writes), and `pslverr <= waddrerr` or `raddrerr` as appropriate.
- `waddr`/`wdata`/`wstrb` hold the captured values while a write is in REQ or WAIT, and are 0 otherwise. `raddr` behaves the same way for reads.
- `prdata` and `pslverr` are non-zero only in RESP.
- If `psel` falls while in REQ or WAIT (a protocol violation): abort to IDLE with no `pready` pulse. A later ack is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, timeout counter 0.
- Minimum transfer is 3 cycles: setup at T0, REQ at T1 (ack in the same cycle), RESP at T2 with `pready = 1`.
- Each extra cycle of ack latency adds one wait state.
- Misaligned or zero-strobe transfers take 2 cycles: setup at T0, RESP at T1.
- `wr_en`/`rd_en` are registered outputs that assert exactly one cycle after the setup phase. They never assert twice for one transfer.
- A back-to-back setup phase is accepted in the cycle after RESP.

## Configuration
- `APB_BRIDGE_TIMEOUT_EN` defined:
  - A counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - When it reaches `TIMEOUT - 1` with no matching ack, go to RESP with `pslverr = 1` and `prdata = 0`.
  - An ack in the same cycle as expiry takes priority.
- `APB_BRIDGE_TIMEOUT_EN` undefined: no counter; WAIT lasts indefinitely.

## Structure
- `apb_bridge_pkg`:
  - state enum `apb_br_state_e` (IDLE, REQ, WAIT, RESP);
  - function `byte_mask(strb)` that expands strobes to a bit mask.
- One sub-module, `apb_bridge_timeout`: the counter plus its expiry flag, instantiated only under the macro.

## Test plan
- Aligned write of 0xA5A5_1234 with `pstrb = 4'b0101` to 0x010, `wack` at T1 -> at T1 `wr_en = 1`, `wdata = 0x00A5_0034`, `wstrb = 4'b0101`, `waddr = 0x010`; at T2 `pready = 1`, `pslverr = 0`.
- Read from 0x020, `rack` 3 cycles after REQ with `rdata = 0xDEAD_BEEF` -> `rd_en` pulses exactly once; `pready` asserts 4 cycles after REQ with `prdata = 0xDEAD_BEEF`.
- Read from 0x021 -> no `rd_en`; `pready = 1` and `pslverr = 1` at T1.
- Write with `raddrerr` and `wack` both high at T1, `waddrerr = 1` -> `pslverr = 1`; `raddrerr` has no effect.
- Macro on, `TIMEOUT = 16`, no ack -> `pready = 1`, `pslverr = 1`, `prdata = 0` 16 cycles after REQ. Macro off -> no `pready` after 100 cycles.
- `prst_n` asserted during WAIT, then a new write -> all outputs 0 immediately; the new transfer completes normally and a stale `wack` is ignored.

Source files
------------

// File: rtl/apb_bridge_pkg.sv
// Shared definitions for apb_slave_bridge: controller state encoding and the
// strobe-to-bit-mask helper used when capturing write data.
package apb_bridge_pkg;

   localparam int MAX_DATA_W = 64;
   localparam int MAX_STRB_W = MAX_DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } apb_br_state_e;

   // Expands each strobe bit into a full byte lane; callers truncate to DATA_W.
   function automatic logic [MAX_DATA_W-1:0] byte_mask(input logic [MAX_STRB_W-1:0] strb);
      logic [MAX_DATA_W-1:0] mask;
      mask = '0;
      for (int i = 0; i < MAX_STRB_W; i++) begin
         mask[8*i +: 8] = {8{strb[i]}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/apb_bridge_timeout.sv
// Acknowledge watchdog for apb_slave_bridge: counts cycles spent waiting on the
// back end and flags expiry on the cycle the count reaches TIMEOUT-1.
module apb_bridge_timeout #(
   parameter int TIMEOUT = 16
) (
   input  logic pclk,
   input  logic prst_n,
   input  logic clr_i,
   input  logic run_i,
   output logic expired_o
);

   localparam int CNT_W = $clog2(TIMEOUT);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (run_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge pclk or negedge prst_n) begin
      if (!prst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = run_i && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/apb_slave_bridge.sv
// APB4 completer bridging transfers to a req/ack register back end.
// Optional acknowledge timeout enabled by defining APB_BRIDGE_TIMEOUT_EN.
module apb_slave_bridge
   import apb_bridge_pkg::*;
#(
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                  pclk,
   input  logic                  prst_n,
   input  logic [ADDR_W-1:0]     paddr,
   input  logic                  psel,
   input  logic                  penable,
   input  logic                  pwrite,
   input  logic [DATA_W-1:0]     pwdata,
   input  logic [DATA_W/8-1:0]   pstrb,
   output logic                  pready,
   output logic [DATA_W-1:0]     prdata,
   output logic                  pslverr,
   output logic                  wr_en,
   output logic                  rd_en,
   output logic [ADDR_W-1:0]     waddr,
   output logic [ADDR_W-1:0]     raddr,
   output logic [DATA_W-1:0]     wdata,
   output logic [DATA_W/8-1:0]   wstrb,
   input  logic                  wack,
   input  logic                  rack,
   input  logic                  waddrerr,
   input  logic                  raddrerr,
   input  logic [DATA_W-1:0]     rdata
);

   localparam int STRB_W = DATA_W / 8;
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STRB_W - 1);

   if (DATA_W % 8 != 0 || DATA_W < 8 || DATA_W > MAX_DATA_W || TIMEOUT < 2) begin : g_bad_params
      $error("apb_slave_bridge: unsupported DATA_W or TIMEOUT");
   end

   apb_br_state_e state_q, state_d;

   logic [ADDR_W-1:0] addr_q;
   logic              write_q;
   logic [DATA_W-1:0] wdata_q;
   logic [STRB_W-1:0] strb_q;
   logic              wr_en_q, wr_en_d;
   logic              rd_en_q, rd_en_d;
   logic              pready_q, pready_d;
   logic [DATA_W-1:0] prdata_q, prdata_d;
   logic              pslverr_q, pslverr_d;

   logic              cap_en;
   logic              misaligned;
   logic              busy;
   logic              ack_match;
   logic              ack_err;
   logic              tmo_expired;
   logic [DATA_W-1:0] strb_mask;

   assign strb_mask  = DATA_W'(byte_mask(MAX_STRB_W'(pstrb)));
   assign misaligned = (paddr & ALIGN_MASK) != '0;
   assign busy       = (state_q == REQ) || (state_q == WAIT);
   assign ack_match  = write_q ? wack : rack;
   assign ack_err    = write_q ? waddrerr : raddrerr;

`ifdef APB_BRIDGE_TIMEOUT_EN
   logic tmo_clr;

   assign tmo_clr = (state_q == IDLE) && (state_d == REQ);

   apb_bridge_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .pclk      (pclk),
      .prst_n    (prst_n),
      .clr_i     (tmo_clr),
      .run_i     (busy),
      .expired_o (tmo_expired)
   );
`else
   assign tmo_expired = 1'b0;
`endif

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      cap_en    = 1'b0;
      wr_en_d   = 1'b0;
      rd_en_d   = 1'b0;
      pready_d  = 1'b0;
      prdata_d  = '0;
      pslverr_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (psel && !penable) begin
               cap_en = 1'b1;
               if (misaligned) begin
                  state_d   = RESP;
                  pready_d  = 1'b1;
                  pslverr_d = 1'b1;
               end else if (pwrite && (pstrb == '0)) begin
                  state_d  = RESP;
                  pready_d = 1'b1;
               end else begin
                  state_d = REQ;
                  wr_en_d = pwrite;
                  rd_en_d = !pwrite;
               end
            end
         end
         REQ, WAIT: begin
            // A master dropping psel mid-transfer abandons it silently.
            if (!psel) begin
               state_d = IDLE;
            end else if (ack_match) begin
               state_d   = RESP;
               pready_d  = 1'b1;
               prdata_d  = write_q ? '0 : rdata;
               pslverr_d = ack_err;
            end else if (tmo_expired) begin
               state_d   = RESP;
               pready_d  = 1'b1;
               pslverr_d = 1'b1;
            end else begin
               state_d = WAIT;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: the capture registers are plain flops, so they share the async reset with the FSM.
   always_ff @(posedge pclk or negedge prst_n) begin
      if (!prst_n) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
         strb_q    <= '0;
         wr_en_q   <= 1'b0;
         rd_en_q   <= 1'b0;
         pready_q  <= 1'b0;
         prdata_q  <= '0;
         pslverr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_en_q   <= wr_en_d;
         rd_en_q   <= rd_en_d;
         pready_q  <= pready_d;
         prdata_q  <= prdata_d;
         pslverr_q <= pslverr_d;
         if (cap_en) begin
            addr_q  <= paddr;
            write_q <= pwrite;
            wdata_q <= pwdata & strb_mask;
            strb_q  <= pstrb;
         end
      end
   end

   assign pready  = pready_q;
   assign prdata  = prdata_q;
   assign pslverr = pslverr_q;
   assign wr_en   = wr_en_q;
   assign rd_en   = rd_en_q;
   assign waddr   = (busy && write_q)  ? addr_q  : '0;
   assign wdata   = (busy && write_q)  ? wdata_q : '0;
   assign wstrb   = (busy && write_q)  ? strb_q  : '0;
   assign raddr   = (busy && !write_q) ? addr_q  : '0;

endmodule

// File: tb/tb_apb_slave_bridge.sv
// Self-checking bench for apb_slave_bridge: directed and randomized APB transfers
// compared against a transaction-level model of the bridge's response rules.
module tb_apb_slave_bridge;

   localparam int ADDR_W  = 12;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 16;
`ifdef APB_BRIDGE_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic              pclk;
   logic              prst_n;
   logic [ADDR_W-1:0] paddr;
   logic              psel, penable, pwrite;
   logic [DATA_W-1:0] pwdata;
   logic [3:0]        pstrb;
   logic              pready;
   logic [DATA_W-1:0] prdata;
   logic              pslverr;
   logic              wr_en, rd_en;
   logic [ADDR_W-1:0] waddr, raddr;
   logic [DATA_W-1:0] wdata;
   logic [3:0]        wstrb;
   logic              wack, rack, waddrerr, raddrerr;
   logic [DATA_W-1:0] rdata;

   int n_checks = 0;
   int n_pass   = 0;

   apb_slave_bridge #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .pclk     (pclk),
      .prst_n   (prst_n),
      .paddr    (paddr),
      .psel     (psel),
      .penable  (penable),
      .pwrite   (pwrite),
      .pwdata   (pwdata),
      .pstrb    (pstrb),
      .pready   (pready),
      .prdata   (prdata),
      .pslverr  (pslverr),
      .wr_en    (wr_en),
      .rd_en    (rd_en),
      .waddr    (waddr),
      .raddr    (raddr),
      .wdata    (wdata),
      .wstrb    (wstrb),
      .wack     (wack),
      .rack     (rack),
      .waddrerr (waddrerr),
      .raddrerr (raddrerr),
      .rdata    (rdata)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic advance();
      @(posedge pclk);
      #1;
   endtask

   task automatic clear_acks();
      wack = 1'b0; rack = 1'b0; waddrerr = 1'b0; raddrerr = 1'b0; rdata = '0;
   endtask

   // One complete APB transfer; the matching ack arrives lat cycles after REQ.
   task automatic do_xfer(input string name, input logic wr, input logic [11:0] addr,
                          input logic [31:0] data, input logic [3:0] strb, input int lat,
                          input logic [31:0] rd, input logic err);
      logic mis, req, tmo, got, exp_err, got_err;
      int exp_cyc, got_cyc, n_wr, n_rd;
      logic [31:0] exp_wd, exp_rd, got_rd;
      mis = (addr % 4) != 0;
      req = !mis && !(wr && strb == 4'b0000);
      tmo = TMO_EN && req && (lat >= TIMEOUT);
      exp_wd = '0;
      for (int b = 0; b < 4; b++) if (strb[b]) exp_wd[8*b +: 8] = data[8*b +: 8];
      if (!req) exp_cyc = 1;
      else if (tmo) exp_cyc = TIMEOUT + 1;
      else exp_cyc = lat + 2;
      exp_rd  = (req && !wr && !tmo) ? rd : 32'h0;
      exp_err = mis || tmo || (req && err);

      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
      got = 1'b0; got_cyc = 0; got_rd = '0; got_err = 1'b0; n_wr = 0; n_rd = 0;
      for (int c = 1; c <= exp_cyc + 4 && !got; c++) begin
         advance();
         penable = 1'b1;
         n_wr += int'(wr_en);
         n_rd += int'(rd_en);
         if (c == 1) begin
            n_checks++;
            if ({wr_en, rd_en, waddr, raddr, wdata, wstrb} !==
                {req && wr, req && !wr, (req && wr) ? addr : 12'h0, (req && !wr) ? addr : 12'h0,
                 (req && wr) ? exp_wd : 32'h0, (req && wr) ? strb : 4'h0})
               $display("FAIL %s req_phase: got wr_en=%b rd_en=%b waddr=%h raddr=%h wdata=%h wstrb=%b expected req=%b wr=%b addr=%h wdata=%h strb=%b",
                        name, wr_en, rd_en, waddr, raddr, wdata, wstrb, req, wr, addr, exp_wd, strb);
            else n_pass++;
         end
         clear_acks();
         if (pready) begin
            got = 1'b1; got_cyc = c; got_rd = prdata; got_err = pslverr;
            n_checks++;
            if ({waddr, raddr, wdata, wstrb} !== '0)
               $display("FAIL %s resp_bus_idle: got waddr=%h raddr=%h wdata=%h wstrb=%b expected all zero",
                        name, waddr, raddr, wdata, wstrb);
            else n_pass++;
         end else if (wr) begin
            wack = (c == lat + 1); waddrerr = err; rack = 1'($urandom_range(0, 1));
            raddrerr = 1'b1; rdata = $urandom;
         end else begin
            rack = (c == lat + 1); raddrerr = err; wack = 1'($urandom_range(0, 1));
            waddrerr = 1'b1; rdata = (c == lat + 1) ? rd : $urandom;
         end
      end

      n_checks++;
      if (!got) $display("FAIL %s pready_timeout: got no pready expected pready after %0d cycles", name, exp_cyc);
      else n_pass++;
      n_checks++;
      if (got_cyc !== exp_cyc) $display("FAIL %s latency: got %0d expected %0d", name, got_cyc, exp_cyc);
      else n_pass++;
      n_checks++;
      if ({got_rd, got_err} !== {exp_rd, exp_err})
         $display("FAIL %s response: got prdata=%h pslverr=%b expected prdata=%h pslverr=%b",
                  name, got_rd, got_err, exp_rd, exp_err);
      else n_pass++;
      n_checks++;
      if (n_wr !== int'(req && wr) || n_rd !== int'(req && !wr))
         $display("FAIL %s req_pulses: got wr=%0d rd=%0d expected wr=%0d rd=%0d",
                  name, n_wr, n_rd, int'(req && wr), int'(req && !wr));
      else n_pass++;

      advance();
      n_checks++;
      if ({pready, pslverr, prdata} !== '0)
         $display("FAIL %s after_resp: got pready=%b pslverr=%b prdata=%h expected zero", name, pready, pslverr, prdata);
      else n_pass++;
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic test_reset();
      prst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
      clear_acks();
      repeat (3) advance();
      n_checks++;
      if ({pready, prdata, pslverr, wr_en, rd_en, waddr, raddr, wdata, wstrb} !== '0)
         $display("FAIL reset_outputs: got pready=%b prdata=%h pslverr=%b wr_en=%b rd_en=%b expected zero",
                  pready, prdata, pslverr, wr_en, rd_en);
      else n_pass++;
      prst_n = 1'b1;
      advance();
   endtask

   task automatic test_directed();
      do_xfer("wr_strb",        1'b1, 12'h010, 32'hA5A5_1234, 4'b0101, 0, 32'h0, 1'b0);
      do_xfer("rd_lat3",        1'b0, 12'h020, 32'h0,         4'b0000, 3, 32'hDEAD_BEEF, 1'b0);
      do_xfer("rd_misaligned",  1'b0, 12'h021, 32'h0,         4'b1111, 0, 32'h1234_5678, 1'b0);
      do_xfer("wr_misaligned",  1'b1, 12'h032, 32'hFFFF_FFFF, 4'b1111, 0, 32'h0, 1'b0);
      do_xfer("wr_waddrerr",    1'b1, 12'h030, 32'h1111_2222, 4'b1111, 0, 32'h0, 1'b1);
      do_xfer("wr_raddrerr_ign",1'b1, 12'h034, 32'h3333_4444, 4'b1100, 1, 32'h0, 1'b0);
      do_xfer("wr_zero_strb",   1'b1, 12'h038, 32'h5555_6666, 4'b0000, 0, 32'h0, 1'b0);
      do_xfer("rd_raddrerr",    1'b0, 12'h03C, 32'h0,         4'b0000, 2, 32'h0BAD_F00D, 1'b1);
   endtask

   task automatic test_random();
      logic [11:0] a;
      for (int i = 0; i < 40; i++) begin
         a = 12'($urandom);
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         do_xfer($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), a, $urandom,
                 4'($urandom_range(0, 15)), $urandom_range(0, 5), $urandom, 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) advance();
      end
   endtask

   task automatic test_timeout();
      int n_rdy;
      if (TMO_EN) begin
         do_xfer("tmo_ack_wins", 1'b0, 12'h040, 32'h0, 4'b0000, TIMEOUT - 1, 32'hCAFE_0001, 1'b0);
         do_xfer("tmo_expire",   1'b0, 12'h044, 32'h0, 4'b0000, 1000, 32'hCAFE_0002, 1'b0);
      end else begin
         psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h048;
         n_rdy = 0;
         for (int c = 0; c < 100; c++) begin
            advance();
            penable = 1'b1;
            n_rdy += int'(pready);
         end
         n_checks++;
         if (n_rdy !== 0) $display("FAIL no_timeout: got %0d pready cycles expected 0", n_rdy);
         else n_pass++;
         psel = 1'b0; penable = 1'b0;
         advance();
      end
   endtask

   task automatic test_abort();
      int n_rdy, n_wr;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h050; pwdata = 32'h0F0F_0F0F; pstrb = 4'hF;
      n_rdy = 0; n_wr = 0;
      for (int c = 0; c < 3; c++) begin
         advance();
         penable = 1'b1;
         n_rdy += int'(pready);
         n_wr  += int'(wr_en);
      end
      psel = 1'b0; penable = 1'b0;
      advance();
      wack = 1'b1; waddrerr = 1'b1;
      for (int c = 0; c < 5; c++) begin
         n_rdy += int'(pready);
         n_wr  += int'(wr_en);
         advance();
      end
      clear_acks();
      n_checks++;
      if (n_rdy !== 0 || n_wr !== 1)
         $display("FAIL abort: got pready_cycles=%0d wr_en_pulses=%0d expected 0 and 1", n_rdy, n_wr);
      else n_pass++;
      n_checks++;
      if ({waddr, wdata, wstrb} !== '0)
         $display("FAIL abort_idle_bus: got waddr=%h wdata=%h wstrb=%b expected zero", waddr, wdata, wstrb);
      else n_pass++;
      do_xfer("after_abort", 1'b0, 12'h054, 32'h0, 4'b0000, 1, 32'h7777_8888, 1'b0);
   endtask

   task automatic test_reset_mid();
      int n_rdy;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h060; pwdata = 32'hABCD_EF01; pstrb = 4'hF;
      advance();
      penable = 1'b1;
      advance();
      advance();
      #2 prst_n = 1'b0;
      #1;
      n_checks++;
      if ({pready, prdata, pslverr, wr_en, rd_en, waddr, raddr, wdata, wstrb} !== '0)
         $display("FAIL reset_mid: got waddr=%h wdata=%h wstrb=%b pready=%b expected zero", waddr, wdata, wstrb, pready);
      else n_pass++;
      psel = 1'b0; penable = 1'b0;
      advance();
      prst_n = 1'b1;
      wack = 1'b1;
      n_rdy = 0;
      for (int c = 0; c < 3; c++) begin
         advance();
         n_rdy += int'(pready);
      end
      clear_acks();
      n_checks++;
      if (n_rdy !== 0) $display("FAIL stale_wack: got %0d pready cycles expected 0", n_rdy);
      else n_pass++;
      do_xfer("after_reset", 1'b1, 12'h064, 32'h1357_9BDF, 4'b1010, 2, 32'h0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_timeout();
      test_abort();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
